// File: rtl/mitchell_mul_pipe.sv
// Pipelined Mitchell logarithmic approximate multiplier with valid/ready stall-all flow control.
// Optional macro MITCHELL_CORR_EN adds a 4x4 fraction-product correction in the s < 1 region.
module mitchell_mul_pipe #(
  parameter int WIDTH_A   = 16,
  parameter int WIDTH_B   = 16,
  parameter int WIDTH_MUL = 32,
  parameter int SIGNED    = 0,
  parameter int FRAC_W    = 15,
  parameter int TAG_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH_A-1:0]   A,
  input  logic [WIDTH_B-1:0]   B,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH_MUL-1:0] OUT,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int KA_W = $clog2(WIDTH_A);
  localparam int KB_W = $clog2(WIDTH_B);
  localparam int K_W  = $clog2(WIDTH_A + WIDTH_B) + 1;
  localparam int M_W  = FRAC_W + 2;
  localparam int P_W  = WIDTH_MUL + FRAC_W + 2;

  generate
    if (WIDTH_MUL < WIDTH_A + WIDTH_B) begin : g_bad_mul_width
      $error("mitchell_mul_pipe: WIDTH_MUL must be >= WIDTH_A + WIDTH_B");
    end
    if (WIDTH_A < 4 || WIDTH_B < 4 || FRAC_W < 4) begin : g_bad_widths
      $error("mitchell_mul_pipe: WIDTH_A, WIDTH_B and FRAC_W must be >= 4");
    end
  endgenerate

  logic advance;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // stage 1: sign, magnitude, zero detect
  logic                s1_valid, s1_sign, s1_zero;
  logic [WIDTH_A-1:0]  s1_ma;
  logic [WIDTH_B-1:0]  s1_mb;
  logic [TAG_W-1:0]    s1_tag;

  // stage 2: log form
  logic                s2_valid, s2_sign, s2_zero;
  logic [KA_W-1:0]     s2_ka;
  logic [KB_W-1:0]     s2_kb;
  logic [FRAC_W-1:0]   s2_fa, s2_fb;
  logic [TAG_W-1:0]    s2_tag;

  // stage 3: summed log as mantissa + shift
  logic                s3_valid, s3_sign, s3_zero;
  logic [M_W-1:0]      s3_mant;
  logic [K_W-1:0]      s3_shift;
  logic [TAG_W-1:0]    s3_tag;

  logic [WIDTH_A-1:0]  abs_a;
  logic [WIDTH_B-1:0]  abs_b;
  logic                in_sign, in_zero;

  always_comb begin
    abs_a   = A;
    abs_b   = B;
    in_sign = 1'b0;
    if (SIGNED != 0) begin
      if (A[WIDTH_A-1]) abs_a = -A;
      if (B[WIDTH_B-1]) abs_b = -B;
      in_sign = A[WIDTH_A-1] ^ B[WIDTH_B-1];
    end
    in_zero = (A == '0) | (B == '0);
  end

  logic [KA_W-1:0]     ka;
  logic [KB_W-1:0]     kb;
  logic [WIDTH_A-2:0]  frac_a;
  logic [WIDTH_B-2:0]  frac_b;
  logic [FRAC_W-1:0]   fa, fb;

  // Shifting the leading one out of the top leaves the fraction left-aligned;
  // appending FRAC_W zeros then right-shifting handles both truncation and padding.
  always_comb begin
    ka = '0;
    kb = '0;
    for (int unsigned i = 0; i < WIDTH_A; i++)
      if (s1_ma[i]) ka = KA_W'(i);
    for (int unsigned i = 0; i < WIDTH_B; i++)
      if (s1_mb[i]) kb = KB_W'(i);
    frac_a = (WIDTH_A-1)'(s1_ma << (KA_W'(WIDTH_A - 1) - ka));
    frac_b = (WIDTH_B-1)'(s1_mb << (KB_W'(WIDTH_B - 1) - kb));
    fa = FRAC_W'({frac_a, {FRAC_W{1'b0}}} >> (WIDTH_A - 1));
    fb = FRAC_W'({frac_b, {FRAC_W{1'b0}}} >> (WIDTH_B - 1));
  end

  logic [FRAC_W:0]   s_sum;
  logic              s_ge1;
  logic [FRAC_W-1:0] c_fix;
  logic [M_W-1:0]    mant;
  logic [K_W-1:0]    shift;

`ifdef MITCHELL_CORR_EN
  logic [7:0] c_prod;
  always_comb begin
    c_prod = 8'(s2_fa[FRAC_W-1 -: 4]) * 8'(s2_fb[FRAC_W-1 -: 4]);
    c_fix  = FRAC_W'({c_prod, {FRAC_W{1'b0}}} >> 8);
  end
`else
  assign c_fix = '0;
`endif

  always_comb begin
    s_sum = {1'b0, s2_fa} + {1'b0, s2_fb};
    s_ge1 = s_sum[FRAC_W];
    if (s_ge1)
      mant = {1'b0, s_sum};
    else
      mant = {2'b01, {FRAC_W{1'b0}}} + {1'b0, s_sum} + {2'b00, c_fix};
    shift = K_W'(s2_ka) + K_W'(s2_kb) + K_W'(s_ge1);
  end

  logic [WIDTH_MUL-1:0] mag, res;

  always_comb begin
    mag = WIDTH_MUL'((P_W'(s3_mant) << s3_shift) >> FRAC_W);
    if (s3_zero)
      res = '0;
    else if (s3_sign)
      res = -mag;
    else
      res = mag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_zero   <= 1'b0;
      s1_ma     <= '0;
      s1_mb     <= '0;
      s1_tag    <= '0;
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_zero   <= 1'b0;
      s2_ka     <= '0;
      s2_kb     <= '0;
      s2_fa     <= '0;
      s2_fb     <= '0;
      s2_tag    <= '0;
      s3_valid  <= 1'b0;
      s3_sign   <= 1'b0;
      s3_zero   <= 1'b0;
      s3_mant   <= '0;
      s3_shift  <= '0;
      s3_tag    <= '0;
      out_valid <= 1'b0;
      OUT       <= '0;
      out_tag   <= '0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s1_sign   <= in_sign;
      s1_zero   <= in_zero;
      s1_ma     <= abs_a;
      s1_mb     <= abs_b;
      s1_tag    <= in_tag;
      s2_valid  <= s1_valid;
      s2_sign   <= s1_sign;
      s2_zero   <= s1_zero;
      s2_ka     <= ka;
      s2_kb     <= kb;
      s2_fa     <= fa;
      s2_fb     <= fb;
      s2_tag    <= s1_tag;
      s3_valid  <= s2_valid;
      s3_sign   <= s2_sign;
      s3_zero   <= s2_zero;
      s3_mant   <= mant;
      s3_shift  <= shift;
      s3_tag    <= s2_tag;
      out_valid <= s3_valid;
      if (s3_valid) begin
        OUT     <= res;
        out_tag <= s3_tag;
      end
    end
  end

endmodule

// File: tb/tb_mitchell_mul_pipe.sv
// Directed-vector bench for mitchell_mul_pipe: unsigned and signed instances,
// stall/stream ordering and mid-flight reset.
module tb_mitchell_mul_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        u_in_valid, u_in_ready, u_out_valid, u_out_ready;
  logic [15:0] u_a, u_b;
  logic [3:0]  u_in_tag, u_out_tag;
  logic [31:0] u_out;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [15:0] s_a, s_b;
  logic [3:0]  s_in_tag, s_out_tag;
  logic [31:0] s_out;

  mitchell_mul_pipe #(.WIDTH_A(16), .WIDTH_B(16), .WIDTH_MUL(32), .SIGNED(0),
                      .FRAC_W(15), .TAG_W(4)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(u_in_valid), .in_ready(u_in_ready),
    .A(u_a), .B(u_b), .in_tag(u_in_tag), .out_valid(u_out_valid),
    .out_ready(u_out_ready), .OUT(u_out), .out_tag(u_out_tag));

  mitchell_mul_pipe #(.WIDTH_A(16), .WIDTH_B(16), .WIDTH_MUL(32), .SIGNED(1),
                      .FRAC_W(15), .TAG_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .A(s_a), .B(s_b), .in_tag(s_in_tag), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .OUT(s_out), .out_tag(s_out_tag));

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Unsigned reference with real arithmetic (fractions are exact in double here).
  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
    int ka, kb;
    real fa, fb, s, c, m;
    longint r;
    ka = 0;
    kb = 0;
    for (int i = 0; i < 16; i++) begin
      if (a[i]) ka = i;
      if (b[i]) kb = i;
    end
    fa = real'(a) / real'(longint'(1) << ka) - 1.0;
    fb = real'(b) / real'(longint'(1) << kb) - 1.0;
    s = fa + fb;
    c = 0.0;
`ifdef MITCHELL_CORR_EN
    c = $floor(fa * 16.0) * $floor(fb * 16.0) / 256.0;
`endif
    if (s < 1.0) m = (1.0 + s + c) * real'(longint'(1) << (ka + kb));
    else         m = s * real'(longint'(1) << (ka + kb + 1));
    r = longint'($floor(m));
    if (a == 16'd0 || b == 16'd0) r = 0;
    return r[31:0];
  endfunction

  typedef struct {
    logic        sgn;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic apply_vec(input vec_t v, input int idx);
    int cnt;
    logic got;
    if (v.sgn) begin s_in_valid = 1'b1; s_a = v.a; s_b = v.b; s_in_tag = 4'(idx); end
    else       begin u_in_valid = 1'b1; u_a = v.a; u_b = v.b; u_in_tag = 4'(idx); end
    @(posedge clk); #1;
    u_in_valid = 1'b0;
    s_in_valid = 1'b0;
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
      got = v.sgn ? s_out_valid : u_out_valid;
    end
    chk($sformatf("vec%0d_latency", idx), 64'(cnt), 64'd3);
    chk($sformatf("vec%0d_out", idx), 64'(v.sgn ? s_out : u_out), 64'(v.exp));
    chk($sformatf("vec%0d_tag", idx), 64'(v.sgn ? s_out_tag : u_out_tag), 64'(idx[3:0]));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] exp_q[$];
    logic [3:0]  tag_q[$];
    logic [15:0] sa[8];
    logic [15:0] sb[8];
    logic [31:0] h_out, e_out;
    logic [3:0]  h_tag, e_tag;
    logic        held, xin, xout, seen;
    int          sent, rcvd, cyc;

    vecs[0]  = '{1'b0, 16'd3,      16'd5,      32'd14};
`ifdef MITCHELL_CORR_EN
    vecs[0].exp = 32'd15;
`endif
    vecs[1]  = '{1'b0, 16'd6,      16'd6,      32'd32};
    vecs[2]  = '{1'b0, 16'd256,    16'd128,    32'd32768};
    vecs[3]  = '{1'b0, 16'd0,      16'hFFFF,   32'd0};
    vecs[4]  = '{1'b0, 16'd1,      16'd1,      32'd1};
    vecs[5]  = '{1'b0, 16'hFFFF,   16'hFFFF,   32'hFFFE0000};
    vecs[6]  = '{1'b0, 16'd7,      16'd1,      32'd7};
    vecs[7]  = '{1'b1, 16'hFFFD,   16'd5,      32'hFFFFFFF2};
`ifdef MITCHELL_CORR_EN
    vecs[7].exp = 32'hFFFFFFF1;
`endif
    vecs[8]  = '{1'b1, 16'h8000,   16'h0002,   32'hFFFF0000};
    vecs[9]  = '{1'b1, 16'd0,      16'hFFFF,   32'd0};
    vecs[10] = '{1'b1, 16'h8000,   16'h8000,   32'h40000000};
    vecs[11] = '{1'b1, 16'hFFFF,   16'hFFFF,   32'd1};

    rst_n = 1'b0;
    u_in_valid = 1'b0; u_a = '0; u_b = '0; u_in_tag = '0; u_out_ready = 1'b1;
    s_in_valid = 1'b0; s_a = '0; s_b = '0; s_in_tag = '0; s_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(u_out_valid), 64'd0);
    chk("rst_out", 64'(u_out), 64'd0);
    chk("rst_out_tag", 64'(u_out_tag), 64'd0);
    chk("rst_in_ready", 64'(u_in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) apply_vec(vecs[i], i);

    // Streaming with random backpressure and input bubbles.
    for (int i = 0; i < 8; i++) begin
      sa[i] = 16'($urandom);
      sb[i] = 16'($urandom);
    end
    sent = 0; rcvd = 0; cyc = 0; held = 1'b0; h_out = '0; h_tag = '0;
    u_in_valid = 1'b1; u_a = sa[0]; u_b = sb[0]; u_in_tag = 4'd0;
    while (rcvd < 8 && cyc < 400) begin
      @(negedge clk);
      u_out_ready = 1'($urandom_range(0, 1));
      #1;
      if (held) begin
        chk("stall_valid", 64'(u_out_valid), 64'd1);
        chk("stall_out", 64'(u_out), 64'(h_out));
        chk("stall_tag", 64'(u_out_tag), 64'(h_tag));
      end
      xin  = u_in_valid & u_in_ready;
      xout = u_out_valid & u_out_ready;
      if (xout) begin
        if (exp_q.size() == 0) begin
          chk("stream_extra_beat", 64'(u_out_tag), 64'hDEAD);
        end else begin
          e_out = exp_q.pop_front();
          e_tag = tag_q.pop_front();
          chk($sformatf("stream%0d_out", rcvd), 64'(u_out), 64'(e_out));
          chk($sformatf("stream%0d_tag", rcvd), 64'(u_out_tag), 64'(e_tag));
        end
        rcvd++;
      end
      held  = u_out_valid & ~u_out_ready;
      h_out = u_out;
      h_tag = u_out_tag;
      @(posedge clk); #1;
      cyc++;
      if (xin) begin
        exp_q.push_back(model(sa[sent], sb[sent]));
        tag_q.push_back(4'(sent));
        sent++;
        if (sent < 8) begin
          u_a = sa[sent]; u_b = sb[sent]; u_in_tag = 4'(sent);
          u_in_valid = ($urandom_range(0, 3) != 0);
        end else begin
          u_in_valid = 1'b0;
        end
      end else if (sent < 8) begin
        u_in_valid = 1'b1;
      end
    end
    chk("stream_count", 64'(rcvd), 64'd8);
    u_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset with one beat on the output and three still inside.
    for (int j = 0; j < 4; j++) begin
      u_in_valid = 1'b1; u_a = 16'd3; u_b = 16'd5; u_in_tag = 4'(j + 1);
      @(posedge clk); #1;
    end
    u_in_valid = 1'b0;
    chk("pre_reset_valid", 64'(u_out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(u_out_valid), 64'd0);
    chk("async_rst_out", 64'(u_out), 64'd0);
    chk("async_rst_tag", 64'(u_out_tag), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      if (u_out_valid) seen = 1'b1;
    end
    chk("no_stale_after_reset", 64'(seen), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
